booth_csa_tree_pipe: RTL and testbench
======================================

BOOTH_CSA_TREE_PIPE -- requirements
Module: booth_csa_tree_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16, multiplicand width; SHALL be even and >= 8.
REQ-002 Derived NUM_PP = DATA_WIDTH/2+1 (partial-product rows); PP_W = DATA_WIDTH+2 (row width); OUT_W = 2*DATA_WIDTH.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 in_valid  input  1  input row set valid.
REQ-006 in_ready  output  1  block can accept input this cycle.
REQ-007 pp_data  input  NUM_PP*PP_W  rows, row i at [i*PP_W +: PP_W].
REQ-008 pp_neg  input  NUM_PP  per-row sign-fill flag (Booth decoder sign).
REQ-009 flag_zero  input  1  1 = rows used; 0 = whole operation forced to zero.
REQ-010 out_valid  output  1  Sum/Carry valid.
REQ-011 out_ready  input  1  downstream accepts output.
REQ-012 sum  output  OUT_W  redundant sum vector.
REQ-013 carry  output  OUT_W  redundant carry vector, weight 2 (unshifted).

Function
REQ-014 Row i extended to OUT_W: bits above PP_W+2i filled with pp_neg[i], row shifted left 2i, truncated to OUT_W; fill width <= 0 means no fill.
REQ-015 flag_zero=0 SHALL make every extended row zero, including sign fill.
REQ-016 Result R = sum + (carry<<1) mod 2^OUT_W SHALL equal sum of all extended rows mod 2^OUT_W.
REQ-017 Reduction SHALL use 3:2 CSA levels only (no carry-propagate adder); carries shifted left 1 between levels, MSB dropped.
REQ-018 Pipeline SHALL have exactly 3 register stages: S1 after first CSA level, S2 after middle levels, S3 after final 3:2 (output regs); each stage holds data plus valid bit.
REQ-019 Level-to-stage partitioning for NUM_PP > 9 SHALL keep S1 at one CSA level and place remaining levels evenly between S2 and S3.
REQ-020 advance = !out_valid | out_ready; in_ready SHALL equal advance combinationally.
REQ-021 Input accepted when in_valid & in_ready; on advance all stages shift by one, S1 valid <= in_valid.
REQ-022 When advance=0, all stage registers SHALL hold; no input accepted; sum/carry stable.
REQ-023 Latency SHALL be 3 cycles: accepted at edge k -> out_valid=1 after edge k+3 with no stall.
REQ-024 Throughput SHALL be one result per cycle while out_ready=1; bubbles not collapsed.
REQ-025 Result order SHALL equal acceptance order; no result lost or duplicated under any out_ready pattern.
REQ-026 Data registers of invalid stages are don't-care internally but sum/carry SHALL read 0 whenever out_valid=0.
REQ-027 Internal in-flight counter (0..3) SHALL increment on accept without output handshake, decrement on output handshake without accept, else hold; exposed only for assertions.

Reset
REQ-028 rstn=1 SHALL asynchronously clear all valid bits, sum=0, carry=0, out_valid=0, counter=0.
REQ-029 While rstn=1, in_ready SHALL be 0; first accept possible at first rising edge after rstn deasserts.
REQ-030 Reset mid-operation SHALL discard all in-flight results; none emitted afterwards.

Verification (DATA_WIDTH=16, 9 rows, 18-bit rows)
REQ-031 Row0=18'h00001, others 0, pp_neg=0, flag_zero=1, out_ready=1 -> out_valid 3 cycles later, R=32'h00000001.
REQ-032 Row0=18'h3FFFF, pp_neg[0]=1, others 0 -> R=32'hFFFFFFFF; same with flag_zero=0 -> R=32'h00000000.
REQ-033 Booth-encode A=16'h1234, B=16'h5678 (unsigned, radix-4) into rows/pp_neg -> R=32'h06260060; repeat 10k random A,B vs reference product.
REQ-034 Back-to-back 4 inputs, out_ready=0 from first out_valid for 5 cycles -> in_ready=0 with 3 in flight, output held constant, then 4 results in order, one per cycle.
REQ-035 Assert rstn for 1 cycle with 2 in flight -> out_valid=0, sum=carry=0 immediately; no stale result after release.
REQ-036 Elaborate DATA_WIDTH=32 (17 rows), random Booth operands -> R matches product, latency 3.

Source files
------------

// File: rtl/booth_csa_tree_pipe.sv
// booth_csa_tree_pipe
//   Reduces the radix-4 Booth partial-product rows of a DATA_WIDTH multiplier
//   to a redundant sum/carry pair. Only 3:2 carry-save levels are used, and
//   there are three register stages:
//     S1 : after the first CSA level
//     S2 : after the middle levels (leaves 3 rows, or more for wide trees)
//     S3 : after the final 3:2 level (output registers)
//   Ports:
//     clk        rising-edge clock
//     rstn       asynchronous reset, ACTIVE-HIGH despite the name
//     in_valid   / in_ready    input handshake (in_ready is 0 during reset)
//     pp_data    NUM_PP rows of PP_W bits, row i at [i*PP_W +: PP_W]
//     pp_neg     per-row sign-fill bit
//     flag_zero  0 forces the whole operation to zero
//     out_valid  / out_ready   output handshake
//     sum, carry redundant result: R = sum + (carry << 1) mod 2^OUT_W
//   The whole pipe advances together when the output slot is free or being
//   drained; bubbles are kept, not collapsed.

package booth_csa_tree_pipe_pkg;
    // Number of rows left after lv levels of 3:2 reduction starting from n.
    function automatic int rows_after(input int n, input int lv);
        int r;
        r = n;
        for (int k = 0; k < lv; k++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int levels_to_two(input int n);
        int r, k;
        r = n;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            if (r > 2) begin
                r = 2 * (r / 3) + r % 3;
                k++;
            end
        end
        return k;
    endfunction
endpackage

// csa_reduce
//   LEVELS levels of 3:2 compression, N_IN rows in, N_OUT rows out. Each
//   level groups rows in threes; leftovers pass through. Carries are shifted
//   left by one within W bits (MSB dropped).
module csa_reduce
    import booth_csa_tree_pipe_pkg::*;
#(
    parameter int W      = 32,
    parameter int N_IN   = 9,
    parameter int LEVELS = 1,
    parameter int N_OUT  = 6
) (
    input  logic [N_IN-1:0][W-1:0]  rows_in,
    output logic [N_OUT-1:0][W-1:0] rows_out
);
    logic [N_IN-1:0][W-1:0] cur, nxt;

    always_comb begin
        int n, g;
        n   = N_IN;
        g   = 0;
        cur = rows_in;
        nxt = '0;
        for (int l = 0; l < LEVELS; l++) begin
            n   = rows_after(N_IN, l);
            g   = n / 3;
            nxt = '0;
            for (int j = 0; j < N_IN / 3; j++) begin
                if (j < g) begin
                    nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
                    nxt[2*j+1] = ((cur[3*j] & cur[3*j+1]) | (cur[3*j] & cur[3*j+2]) |
                                  (cur[3*j+1] & cur[3*j+2])) << 1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (3 * g + k < n) nxt[2*g+k] = cur[3*g+k];
            end
            cur = nxt;
        end
        rows_out = cur[N_OUT-1:0];
    end
endmodule

module booth_csa_tree_pipe
    import booth_csa_tree_pipe_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int NUM_PP     = DATA_WIDTH / 2 + 1,
    localparam int PP_W       = DATA_WIDTH + 2,
    localparam int OUT_W      = 2 * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PP*PP_W-1:0] pp_data,
    input  logic [NUM_PP-1:0]      pp_neg,
    input  logic                   flag_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       sum,
    output logic [OUT_W-1:0]       carry
);
    localparam int STAGES = 3;
    localparam int L_TOT  = levels_to_two(NUM_PP);
    // Wide trees split the remaining levels evenly; S3 always ends with the
    // final 3:2, which is applied outside csa_reduce (carry left unshifted).
    localparam int L_S3   = (NUM_PP > 9) ? (L_TOT - 1) / 2 : 1;
    localparam int L_S2   = L_TOT - 1 - L_S3;
    localparam int N1     = rows_after(NUM_PP, 1);
    localparam int N2     = rows_after(NUM_PP, 1 + L_S2);

    if (DATA_WIDTH % 2 != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("DATA_WIDTH must be even and >= 8");
    end

    // Row extension: sign fill above the row, shift by 2i, truncate.
    logic [NUM_PP-1:0][OUT_W-1:0] ext;
    always_comb begin
        logic [2*OUT_W-1:0] t;
        t   = '0;
        ext = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            t      = {{(2*OUT_W-PP_W){pp_neg[i]}}, pp_data[i*PP_W +: PP_W]} << (2 * i);
            ext[i] = flag_zero ? t[OUT_W-1:0] : '0;
        end
    end

    logic [N1-1:0][OUT_W-1:0] s1_d, s1_q;
    logic [N2-1:0][OUT_W-1:0] s2_d, s2_q;
    logic [2:0][OUT_W-1:0]    s3_rows;
    logic [OUT_W-1:0]         sum_d, carry_d, sum_q, carry_q;
    logic [STAGES:1]          vld_pipe;
    logic [1:0]               in_flight;
    logic                     advance, accept, out_hs;

    csa_reduce #(.W(OUT_W), .N_IN(NUM_PP), .LEVELS(1), .N_OUT(N1)) u_lvl_s1 (
        .rows_in(ext), .rows_out(s1_d));
    csa_reduce #(.W(OUT_W), .N_IN(N1), .LEVELS(L_S2), .N_OUT(N2)) u_lvl_s2 (
        .rows_in(s1_q), .rows_out(s2_d));
    csa_reduce #(.W(OUT_W), .N_IN(N2), .LEVELS(L_S3 - 1), .N_OUT(3)) u_lvl_s3 (
        .rows_in(s2_q), .rows_out(s3_rows));

    assign sum_d   = s3_rows[0] ^ s3_rows[1] ^ s3_rows[2];
    assign carry_d = (s3_rows[0] & s3_rows[1]) | (s3_rows[0] & s3_rows[2]) |
                     (s3_rows[1] & s3_rows[2]);

    assign out_valid = vld_pipe[STAGES];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !rstn;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign sum       = sum_q;
    assign carry     = carry_q;

    // Control and output registers; outputs are zeroed whenever invalid.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            vld_pipe  <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            in_flight <= '0;
        end else begin
            if (advance) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
                sum_q    <= vld_pipe[2] ? sum_d : '0;
                carry_q  <= vld_pipe[2] ? carry_d : '0;
            end
            if (accept && !out_hs)      in_flight <= in_flight + 2'd1;
            else if (!accept && out_hs) in_flight <= in_flight - 2'd1;
        end
    end

    // Inner data registers carry no reset: contents of invalid stages are
    // never observed.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    a_in_flight : assert property (@(posedge clk) disable iff (rstn)
        int'(in_flight) == $countones(vld_pipe));
endmodule

// File: tb/tb_booth_csa_tree_pipe.sv
module tb_booth_csa_tree_pipe;
    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b1, flag_zero = 1'b1;
    logic [161:0] pp_data = '0;
    logic [8:0]   pp_neg = '0;
    logic         in_ready, out_valid;
    logic [31:0]  sum, carry;

    logic         w_in_valid = 1'b0, w_out_ready = 1'b1, w_flag_zero = 1'b1;
    logic [577:0] w_pp_data = '0;
    logic [16:0]  w_pp_neg = '0;
    logic         w_in_ready, w_out_valid;
    logic [63:0]  w_sum, w_carry;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_csa_tree_pipe #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .pp_data(pp_data), .pp_neg(pp_neg), .flag_zero(flag_zero),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry));

    booth_csa_tree_pipe #(.DATA_WIDTH(32)) dut_w (
        .clk(clk), .rstn(rstn), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .pp_data(w_pp_data), .pp_neg(w_pp_neg), .flag_zero(w_flag_zero),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum), .carry(w_carry));

    // Radix-4 Booth digit i of unsigned b times a, as a (w+2)-bit two's complement row.
    function automatic logic [33:0] booth_row(input logic [31:0] a, input logic [31:0] b,
                                              input int i, input int w);
        logic [35:0] bx;
        int          d;
        longint      p;
        logic [63:0] m;
        bx = {4'b0, b} << 1;
        d  = int'(bx[2*i+1]) + int'(bx[2*i]) - 2 * int'(bx[2*i+2]);
        p  = longint'(d) * longint'({32'b0, a});
        m  = (64'd1 << (w + 2)) - 64'd1;
        return 34'(64'(p) & m);
    endfunction

    function automatic void enc16(input logic [15:0] a, input logic [15:0] b,
                                  output logic [161:0] d, output logic [8:0] ng);
        logic [33:0] rw;
        d = '0;
        ng = '0;
        for (int i = 0; i < 9; i++) begin
            rw = booth_row({16'b0, a}, {16'b0, b}, i, 16);
            d[i*18 +: 18] = rw[17:0];
            ng[i] = rw[17];
        end
    endfunction

    function automatic void enc32(input logic [31:0] a, input logic [31:0] b,
                                  output logic [577:0] d, output logic [16:0] ng);
        logic [33:0] rw;
        d = '0;
        ng = '0;
        for (int i = 0; i < 17; i++) begin
            rw = booth_row(a, b, i, 32);
            d[i*34 +: 34] = rw;
            ng[i] = rw[33];
        end
    endfunction

    // Value of arbitrary rows: sign-extended, weighted by 4^i, summed mod 2^32.
    function automatic logic [31:0] raw_ref(input logic [161:0] d, input logic [8:0] ng,
                                            input logic fz);
        logic [63:0] v, acc;
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            v = {46'b0, d[i*18 +: 18]};
            if (ng[i]) v = v | (~64'd0 << 18);
            acc = acc + (v << (2 * i));
        end
        return fz ? acc[31:0] : 32'd0;
    endfunction

    // Drive one cycle of narrow inputs after the falling edge and observe.
    task automatic step(input logic iv, input logic [161:0] d, input logic [8:0] ng,
                        input logic fz, input logic ordy,
                        output logic acc, output logic ohs, output logic [31:0] r);
        @(negedge clk);
        in_valid = iv; pp_data = d; pp_neg = ng; flag_zero = fz; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        ohs = out_valid && out_ready;
        r   = sum + (carry << 1);
    endtask

    task automatic test_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (sum !== 32'd0 || carry !== 32'd0) begin n_bad++; $display("FAIL reset_sum_carry got %h/%h want 0/0", sum, carry); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_hold_valid got %b want 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        logic [161:0] d;
        logic acc, ohs;
        logic [31:0] r;
        d = '0; d[17:0] = 18'h00001;
        step(1'b1, d, 9'd0, 1'b1, 1'b1, acc, ohs, r);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL lat_accept got %b want 1", acc); end
        for (int c = 1; c <= 3; c++) begin
            step(1'b0, '0, '0, 1'b1, 1'b1, acc, ohs, r);
            n_cmp++;
            if (out_valid !== (c == 3)) begin n_bad++; $display("FAIL lat_valid_c%0d got %b want %b", c, out_valid, c == 3); end
        end
        n_cmp++; if (r !== 32'h00000001) begin n_bad++; $display("FAIL lat_result got %h want 00000001", r); end
        step(1'b0, '0, '0, 1'b1, 1'b1, acc, ohs, r);
        n_cmp++; if (out_valid !== 1'b0 || sum !== 32'd0 || carry !== 32'd0) begin
            n_bad++; $display("FAIL idle_zero got v=%b s=%h c=%h want 0/0/0", out_valid, sum, carry); end
    endtask

    task automatic test_sign_fill();
        logic [161:0] d;
        logic acc, ohs;
        logic [31:0] r;
        logic [31:0] want [2];
        int got;
        want[0] = 32'hFFFFFFFF; want[1] = 32'h00000000;
        d = '0; d[17:0] = 18'h3FFFF;
        step(1'b1, d, 9'd1, 1'b1, 1'b1, acc, ohs, r);
        step(1'b1, d, 9'd1, 1'b0, 1'b1, acc, ohs, r);
        got = 0;
        for (int c = 0; c < 8 && got < 2; c++) begin
            step(1'b0, '0, '0, 1'b1, 1'b1, acc, ohs, r);
            if (ohs) begin
                n_cmp++;
                if (r !== want[got]) begin n_bad++; $display("FAIL sign_fill_%0d got %h want %h", got, r, want[got]); end
                got++;
            end
        end
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL sign_fill_count got %0d want 2", got); end
    endtask

    task automatic test_booth_random(input int n);
        logic [31:0] q[$];
        logic [15:0] a, b;
        logic [161:0] d;
        logic [8:0] ng;
        logic acc, ohs, iv;
        logic [31:0] r, e;
        int sent, errs;
        sent = 0; errs = 0;
        a = 16'h1234; b = 16'h5678;
        while (sent < n) begin
            enc16(a, b, d, ng);
            iv = ($urandom_range(0, 9) < 8);
            step(iv, d, ng, 1'b1, ($urandom_range(0, 9) < 7), acc, ohs, r);
            if (ohs) begin
                e = q.pop_front();
                n_cmp++;
                if (r !== e) begin
                    n_bad++; errs++;
                    if (errs < 10) $display("FAIL booth_prod got %h want %h", r, e);
                end
            end
            if (acc) begin
                q.push_back(sent == 0 ? 32'h06260060 : {16'b0, a} * {16'b0, b});
                sent++;
                a = 16'($urandom); b = 16'($urandom);
            end
        end
        for (int c = 0; c < 50 && q.size() > 0; c++) begin
            step(1'b0, '0, '0, 1'b1, 1'b1, acc, ohs, r);
            if (ohs) begin
                e = q.pop_front();
                n_cmp++;
                if (r !== e) begin n_bad++; $display("FAIL booth_drain got %h want %h", r, e); end
            end
        end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL booth_lost got %0d left want 0", q.size()); end
    endtask

    task automatic test_raw_rows(input int n);
        logic [31:0] q[$];
        logic [161:0] d;
        logic [8:0] ng;
        logic fz, acc, ohs;
        logic [31:0] r, e;
        for (int k = 0; k < n + 4; k++) begin
            for (int w = 0; w < 6; w++) d[w*32 +: 32] = $urandom;
            ng = 9'($urandom);
            fz = ($urandom_range(0, 7) != 0);
            step(k < n, d, ng, fz, 1'b1, acc, ohs, r);
            if (ohs) begin
                e = q.pop_front();
                n_cmp++;
                if (r !== e) begin n_bad++; $display("FAIL raw_rows got %h want %h", r, e); end
            end
            if (acc) q.push_back(raw_ref(d, ng, fz));
        end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL raw_lost got %0d left want 0", q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [15:0] a, b;
        logic [161:0] d;
        logic [8:0] ng;
        logic [31:0] hs, hc, r, e;
        int sent, stall, pops, first_pop, last_pop;
        bit seen;
        sent = 0; stall = 0; pops = 0; seen = 0; first_pop = -1; last_pop = -1;
        hs = '0; hc = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a = 16'($urandom); b = 16'($urandom);
            enc16(a, b, d, ng);
            @(negedge clk);
            if (out_valid) seen = 1;
            out_ready = !(seen && stall < 5);
            in_valid = (sent < 4); pp_data = d; pp_neg = ng; flag_zero = 1'b1;
            #1;
            if (seen && stall < 5) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
                n_cmp++; if (dut.in_flight !== 2'd3) begin n_bad++; $display("FAIL b2b_in_flight got %0d want 3", dut.in_flight); end
                if (stall == 0) begin hs = sum; hc = carry; end
                else begin
                    n_cmp++; if (sum !== hs || carry !== hc) begin n_bad++; $display("FAIL b2b_hold got %h/%h want %h/%h", sum, carry, hs, hc); end
                end
                stall++;
            end
            if (out_valid && out_ready) begin
                r = sum + (carry << 1);
                e = q.pop_front();
                n_cmp++; if (r !== e) begin n_bad++; $display("FAIL b2b_order got %h want %h", r, e); end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc; pops++;
            end
            if (in_valid && in_ready) begin q.push_back({16'b0, a} * {16'b0, b}); sent++; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (pops != 4 || last_pop - first_pop != 3) begin
            n_bad++; $display("FAIL b2b_rate got %0d pops span %0d want 4 span 3", pops, last_pop - first_pop); end
    endtask

    task automatic test_reset_midop();
        logic [161:0] d;
        logic acc, ohs;
        logic [31:0] r;
        int stale;
        d = '0; d[17:0] = 18'h00055;
        step(1'b1, d, '0, 1'b1, 1'b0, acc, ohs, r);
        step(1'b1, d, '0, 1'b1, 1'b0, acc, ohs, r);
        step(1'b0, d, '0, 1'b1, 1'b0, acc, ohs, r);
        step(1'b0, d, '0, 1'b1, 1'b0, acc, ohs, r);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
        rstn = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || sum !== 32'd0 || carry !== 32'd0) begin
            n_bad++; $display("FAIL rst_async got v=%b s=%h c=%h want 0/0/0", out_valid, sum, carry); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        rstn = 1'b0;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, '0, 1'b1, 1'b1, acc, ohs, r);
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rst_stale got %0d want 0", stale); end
    endtask

    task automatic test_wide(input int n);
        logic [63:0] qv[$];
        int qc[$];
        logic [31:0] a, b;
        logic [577:0] d;
        logic [16:0] ng;
        logic [63:0] r, e;
        int sent, ec, errs;
        sent = 0; errs = 0;
        for (int cyc = 0; cyc < n + 6; cyc++) begin
            a = $urandom; b = $urandom;
            if (cyc == 0) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
            enc32(a, b, d, ng);
            @(negedge clk);
            w_in_valid = (sent < n); w_pp_data = d; w_pp_neg = ng; w_flag_zero = 1'b1; w_out_ready = 1'b1;
            #1;
            if (w_out_valid && w_out_ready) begin
                r = w_sum + (w_carry << 1);
                e = qv.pop_front(); ec = qc.pop_front();
                n_cmp++;
                if (r !== e || cyc - ec != 3) begin
                    n_bad++; errs++;
                    if (errs < 10) $display("FAIL wide_prod got %h lat %0d want %h lat 3", r, cyc - ec, e);
                end
            end
            if (w_in_valid && w_in_ready) begin
                qv.push_back({32'b0, a} * {32'b0, b}); qc.push_back(cyc); sent++;
            end
        end
        w_in_valid = 1'b0;
        n_cmp++; if (qv.size() != 0) begin n_bad++; $display("FAIL wide_lost got %0d left want 0", qv.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sign_fill();
        test_back_to_back();
        test_reset_midop();
        test_raw_rows(200);
        test_booth_random(10000);
        test_wide(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
